// File: rtl/id_ex_stage_pkg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_pkg
//   Shared types for the ID/EX pipeline stage of the RISC-V Lite core.
//   - ALUControl_Enum : ALU operation encoding. ADD is encoding 0, so the
//                       bubble and reset value is ADD.
//   - fwd_sel_t       : operand forwarding source select.
//   - id_ex_ctrl_t    : control bits carried from ID into EX.
//   - REG_X0          : index of the hard-wired zero register.
// ---------------------------------------------------------------------------
package id_ex_stage_pkg;

  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    SLL  = 4'd2,
    SLT  = 4'd3,
    SLTU = 4'd4,
    XOR  = 4'd5,
    SRL  = 4'd6,
    SRA  = 4'd7,
    OR   = 4'd8,
    AND  = 4'd9
  } ALUControl_Enum;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_t;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic           valid;
    logic           reg_write;
    logic           mem_read;
    logic           mem_write;
    logic           branch;
    logic           alu_src_pc;
    logic           alu_src_imm;
    ALUControl_Enum alu_ctrl;
  } id_ex_ctrl_t;

  // Control word of an inserted bubble: nothing is written, ALU does ADD.
  localparam id_ex_ctrl_t CTRL_BUBBLE = '{
    valid:       1'b0,
    reg_write:   1'b0,
    mem_read:    1'b0,
    mem_write:   1'b0,
    branch:      1'b0,
    alu_src_pc:  1'b0,
    alu_src_imm: 1'b0,
    alu_ctrl:    ADD
  };

endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// ---------------------------------------------------------------------------
// fwd_unit
//   Pure combinational forwarding-source selection for both EX source
//   operands. The EX/MEM result takes priority over MEM/WB because it is the
//   younger write to the same register. x0 is never forwarded.
//   Ports:
//     rs1_addr_i, rs2_addr_i     registered source indices of the EX instr
//     mem_rd_addr_i, mem_reg_write_i   EX/MEM destination
//     wb_rd_addr_i,  wb_reg_write_i    MEM/WB destination
//     rs1_sel_o, rs2_sel_o       selected source per operand
// ---------------------------------------------------------------------------
module fwd_unit
  import id_ex_stage_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] rs2_addr_i,
  input  logic [REG_ADDR_W-1:0] mem_rd_addr_i,
  input  logic                  mem_reg_write_i,
  input  logic [REG_ADDR_W-1:0] wb_rd_addr_i,
  input  logic                  wb_reg_write_i,
  output fwd_sel_t              rs1_sel_o,
  output fwd_sel_t              rs2_sel_o
);

  localparam logic [REG_ADDR_W-1:0] X0 = REG_ADDR_W'(REG_X0);

  function automatic fwd_sel_t pick(input logic [REG_ADDR_W-1:0] rs);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (rs != X0) begin
      if (mem_reg_write_i && (mem_rd_addr_i == rs)) begin
        sel = FWD_MEM;
      end else if (wb_reg_write_i && (wb_rd_addr_i == rs)) begin
        sel = FWD_WB;
      end
    end
    return sel;
  endfunction

  always_comb begin
    rs1_sel_o = pick(rs1_addr_i);
    rs2_sel_o = pick(rs2_addr_i);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register with operand forwarding and load-use hazard
//   detection for the RISC-V Lite core.
//
//   Inputs : id_* decoded fields of the ID instruction, flush (taken branch
//            kills ID), mem_* / wb_* forwarding sources.
//   Outputs: stall_id (hold PC and IF/ID), ex_* fields of the EX instruction,
//            ex_op1/ex_op2 (ALU operands after forwarding and muxing),
//            ex_store_data (forwarded rs2).
//
//   Optional: define ID_EX_PERF_CNT_EN to add perf_stall_cnt/perf_flush_cnt,
//   wrapping 32-bit counts of stall cycles and flush cycles.
// ---------------------------------------------------------------------------
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [XLEN-1:0]       id_pc,
  input  logic [XLEN-1:0]       id_rs1_data,
  input  logic [XLEN-1:0]       id_rs2_data,
  input  logic [XLEN-1:0]       id_imm,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic [REG_ADDR_W-1:0] id_rd_addr,
  input  ALUControl_Enum        id_alu_ctrl,
  input  logic                  id_alu_src_pc,
  input  logic                  id_alu_src_imm,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_branch,
  input  logic                  flush,
  input  logic [REG_ADDR_W-1:0] mem_rd_addr,
  input  logic                  mem_reg_write,
  input  logic [XLEN-1:0]       mem_alu_result,
  input  logic [REG_ADDR_W-1:0] wb_rd_addr,
  input  logic                  wb_reg_write,
  input  logic [XLEN-1:0]       wb_data,
  output logic                  stall_id,
  output logic                  ex_valid,
  output logic [XLEN-1:0]       ex_op1,
  output logic [XLEN-1:0]       ex_op2,
  output ALUControl_Enum        ex_alu_ctrl,
  output logic [XLEN-1:0]       ex_store_data,
  output logic [XLEN-1:0]       ex_pc,
  output logic [XLEN-1:0]       ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rd_addr,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_branch
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]           perf_stall_cnt,
  output logic [31:0]           perf_flush_cnt
`endif
);

  // -------------------------------------------------------------------------
  // Pipeline register state
  // -------------------------------------------------------------------------
  id_ex_ctrl_t           ctrl_q,     ctrl_d;
  logic [XLEN-1:0]       pc_q,       pc_d;
  logic [XLEN-1:0]       imm_q,      imm_d;
  logic [XLEN-1:0]       rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]       rs2_data_q, rs2_data_d;
  logic [REG_ADDR_W-1:0] rs1_addr_q, rs1_addr_d;
  logic [REG_ADDR_W-1:0] rs2_addr_q, rs2_addr_d;
  logic [REG_ADDR_W-1:0] rd_addr_q,  rd_addr_d;

  logic load_use;
  logic load_bubble;

  // -------------------------------------------------------------------------
  // Load-use hazard: the load in EX cannot forward its data in time to the
  // dependent instruction in ID. rs2 only matters when it is actually read:
  // as the second ALU operand or as store data.
  // -------------------------------------------------------------------------
  always_comb begin
    load_use = 1'b0;
    if (ctrl_q.valid && ctrl_q.mem_read && (rd_addr_q != '0) && id_valid) begin
      if (rd_addr_q == id_rs1_addr) begin
        load_use = 1'b1;
      end else if ((rd_addr_q == id_rs2_addr) && (!id_alu_src_imm || id_mem_write)) begin
        load_use = 1'b1;
      end
    end
  end

  // A flush kills the ID instruction anyway, so it must not also stall fetch.
  assign stall_id    = load_use & ~flush;
  assign load_bubble = load_use | flush;

  // -------------------------------------------------------------------------
  // Next-state: ID fields, or a fully cleared bubble. Clearing the rs
  // addresses keeps the bubble from matching any forwarding source.
  // -------------------------------------------------------------------------
  always_comb begin
    ctrl_d             = CTRL_BUBBLE;
    pc_d               = '0;
    imm_d              = '0;
    rs1_data_d         = '0;
    rs2_data_d         = '0;
    rs1_addr_d         = '0;
    rs2_addr_d         = '0;
    rd_addr_d          = '0;
    if (!load_bubble) begin
      ctrl_d.valid       = id_valid;
      ctrl_d.reg_write   = id_reg_write;
      ctrl_d.mem_read    = id_mem_read;
      ctrl_d.mem_write   = id_mem_write;
      ctrl_d.branch      = id_branch;
      ctrl_d.alu_src_pc  = id_alu_src_pc;
      ctrl_d.alu_src_imm = id_alu_src_imm;
      ctrl_d.alu_ctrl    = id_alu_ctrl;
      pc_d               = id_pc;
      imm_d              = id_imm;
      rs1_data_d         = id_rs1_data;
      rs2_data_d         = id_rs2_data;
      rs1_addr_d         = id_rs1_addr;
      rs2_addr_d         = id_rs2_addr;
      rd_addr_d          = id_rd_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q     <= CTRL_BUBBLE;
      pc_q       <= '0;
      imm_q      <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rd_addr_q  <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      pc_q       <= pc_d;
      imm_q      <= imm_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      rs1_addr_q <= rs1_addr_d;
      rs2_addr_q <= rs2_addr_d;
      rd_addr_q  <= rd_addr_d;
    end
  end

  // -------------------------------------------------------------------------
  // Forwarding and operand selection
  // -------------------------------------------------------------------------
  fwd_sel_t        rs1_sel;
  fwd_sel_t        rs2_sel;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  fwd_unit #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_fwd_unit (
    .rs1_addr_i      (rs1_addr_q),
    .rs2_addr_i      (rs2_addr_q),
    .mem_rd_addr_i   (mem_rd_addr),
    .mem_reg_write_i (mem_reg_write),
    .wb_rd_addr_i    (wb_rd_addr),
    .wb_reg_write_i  (wb_reg_write),
    .rs1_sel_o       (rs1_sel),
    .rs2_sel_o       (rs2_sel)
  );

  always_comb begin
    fwd_rs1 = rs1_data_q;
    case (rs1_sel)
      FWD_MEM: fwd_rs1 = mem_alu_result;
      FWD_WB:  fwd_rs1 = wb_data;
      default: fwd_rs1 = rs1_data_q;
    endcase
    fwd_rs2 = rs2_data_q;
    case (rs2_sel)
      FWD_MEM: fwd_rs2 = mem_alu_result;
      FWD_WB:  fwd_rs2 = wb_data;
      default: fwd_rs2 = rs2_data_q;
    endcase
  end

  assign ex_op1        = ctrl_q.alu_src_pc  ? pc_q  : fwd_rs1;
  assign ex_op2        = ctrl_q.alu_src_imm ? imm_q : fwd_rs2;
  assign ex_store_data = fwd_rs2;

  assign ex_valid     = ctrl_q.valid;
  assign ex_alu_ctrl  = ctrl_q.alu_ctrl;
  assign ex_pc        = pc_q;
  assign ex_imm       = imm_q;
  assign ex_rd_addr   = rd_addr_q;
  assign ex_reg_write = ctrl_q.reg_write;
  assign ex_mem_read  = ctrl_q.mem_read;
  assign ex_mem_write = ctrl_q.mem_write;
  assign ex_branch    = ctrl_q.branch;

`ifdef ID_EX_PERF_CNT_EN
  // -------------------------------------------------------------------------
  // Performance counters, free-running and wrapping.
  // -------------------------------------------------------------------------
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, stall_id};
    flush_cnt_d = flush_cnt_q + {31'd0, flush};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  logic           clk;
  logic           rst_n;
  logic           id_valid;
  logic [31:0]    id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]     id_rs1_addr, id_rs2_addr, id_rd_addr;
  ALUControl_Enum id_alu_ctrl;
  logic           id_alu_src_pc, id_alu_src_imm;
  logic           id_reg_write, id_mem_read, id_mem_write, id_branch;
  logic           flush;
  logic [4:0]     mem_rd_addr, wb_rd_addr;
  logic           mem_reg_write, wb_reg_write;
  logic [31:0]    mem_alu_result, wb_data;
  logic           stall_id, ex_valid;
  logic [31:0]    ex_op1, ex_op2, ex_store_data, ex_pc, ex_imm;
  ALUControl_Enum ex_alu_ctrl;
  logic [4:0]     ex_rd_addr;
  logic           ex_reg_write, ex_mem_read, ex_mem_write, ex_branch;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0]    perf_stall_cnt, perf_flush_cnt;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_alu_ctrl(id_alu_ctrl), .id_alu_src_pc(id_alu_src_pc), .id_alu_src_imm(id_alu_src_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_branch(id_branch), .flush(flush),
    .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write), .mem_alu_result(mem_alu_result),
    .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
    .stall_id(stall_id), .ex_valid(ex_valid), .ex_op1(ex_op1), .ex_op2(ex_op2),
    .ex_alu_ctrl(ex_alu_ctrl), .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_branch(ex_branch)
`ifdef ID_EX_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    // ID stimulus
    logic           valid;
    logic [31:0]    pc, rs1_data, rs2_data, imm;
    logic [4:0]     rs1, rs2, rd;
    ALUControl_Enum alu;
    logic           src_pc, src_imm, reg_write;
    // forwarding sources while the instruction sits in EX
    logic [4:0]     m_rd;  logic m_we; logic [31:0] m_val;
    logic [4:0]     w_rd;  logic w_we; logic [31:0] w_val;
    // expected EX outputs
    logic [31:0]    e_op1, e_op2, e_store;
  } vec_t;

  vec_t vecs[8];
  vec_t sb[$];

  function automatic vec_t mk(
      input logic v, input logic [31:0] pc, input logic [4:0] rs1, input logic [31:0] d1,
      input logic [4:0] rs2, input logic [31:0] d2, input logic [31:0] imm,
      input ALUControl_Enum alu, input logic spc, input logic simm,
      input logic [4:0] mrd, input logic mwe, input logic [31:0] mval,
      input logic [4:0] wrd, input logic wwe, input logic [31:0] wval,
      input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] es);
    vec_t r;
    r.valid = v; r.pc = pc; r.rs1 = rs1; r.rs1_data = d1; r.rs2 = rs2; r.rs2_data = d2;
    r.imm = imm; r.rd = 5'd12; r.alu = alu; r.src_pc = spc; r.src_imm = simm; r.reg_write = 1'b1;
    r.m_rd = mrd; r.m_we = mwe; r.m_val = mval; r.w_rd = wrd; r.w_we = wwe; r.w_val = wval;
    r.e_op1 = e1; r.e_op2 = e2; r.e_store = es;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_fwd();
    mem_rd_addr = '0; mem_reg_write = 1'b0; mem_alu_result = '0;
    wb_rd_addr  = '0; wb_reg_write  = 1'b0; wb_data        = '0;
  endtask

  task automatic drive_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                          input logic [31:0] d1, input logic [4:0] rs2, input logic [31:0] d2,
                          input logic [31:0] imm, input logic [4:0] rd, input ALUControl_Enum alu,
                          input logic spc, input logic simm, input logic rw, input logic mr,
                          input logic mw);
    id_valid = v; id_pc = pc; id_rs1_addr = rs1; id_rs1_data = d1; id_rs2_addr = rs2;
    id_rs2_data = d2; id_imm = imm; id_rd_addr = rd; id_alu_ctrl = alu;
    id_alu_src_pc = spc; id_alu_src_imm = simm; id_reg_write = rw; id_mem_read = mr;
    id_mem_write = mw; id_branch = 1'b0;
  endtask

  initial begin
    vec_t e;
    rst_n = 1'b0;
    flush = 1'b0;
    clear_fwd();
    drive_id(1'b0, '0, '0, '0, '0, '0, '0, '0, ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // v, pc, rs1, d1, rs2, d2, imm, alu, spc, simm, mrd, mwe, mval, wrd, wwe, wval, e_op1, e_op2, e_store
    vecs[0] = mk(1, 32'h0, 5'd5, 32'h10, 5'd6, 32'h20, 32'h0, ADD, 0, 0,
                 5'd0, 0, 32'h0, 5'd0, 0, 32'h0, 32'h10, 32'h20, 32'h20);
    vecs[1] = mk(1, 32'h4, 5'd3, 32'h33, 5'd4, 32'h44, 32'h0, ADD, 0, 0,
                 5'd3, 1, 32'hAAAA, 5'd3, 1, 32'hBBBB, 32'hAAAA, 32'h44, 32'h44);
    vecs[2] = mk(1, 32'h8, 5'd3, 32'h33, 5'd4, 32'h44, 32'h0, ADD, 0, 0,
                 5'd3, 0, 32'hAAAA, 5'd3, 1, 32'hBBBB, 32'hBBBB, 32'h44, 32'h44);
    vecs[3] = mk(1, 32'hC, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, OR, 0, 0,
                 5'd0, 1, 32'h1234, 5'd0, 1, 32'h5678, 32'h0, 32'h0, 32'h0);
    vecs[4] = mk(1, 32'h100, 5'd2, 32'h22, 5'd9, 32'h99, 32'hFFFF_FFF0, ADD, 1, 1,
                 5'd2, 1, 32'h7777, 5'd9, 1, 32'h5555, 32'h100, 32'hFFFF_FFF0, 32'h5555);
    vecs[5] = mk(1, 32'h14, 5'd10, 32'hA0, 5'd11, 32'hB0, 32'h0, XOR, 0, 0,
                 5'd11, 1, 32'hC0DE, 5'd10, 1, 32'hBEEF, 32'hBEEF, 32'hC0DE, 32'hC0DE);
    vecs[6] = mk(1, 32'h18, 5'd13, 32'h130, 5'd14, 32'h140, 32'h0, SUB, 0, 0,
                 5'd13, 0, 32'h1, 5'd14, 0, 32'h2, 32'h130, 32'h140, 32'h140);
    vecs[7] = mk(0, 32'h1C, 5'd15, 32'h150, 5'd16, 32'h160, 32'h8, AND, 0, 1,
                 5'd0, 0, 32'h0, 5'd16, 1, 32'h9, 32'h150, 32'h8, 32'h9);

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    chk("reset_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("reset_alu_ctrl", {28'd0, ex_alu_ctrl}, {28'd0, ADD});
    chk("reset_op1", ex_op1, 32'h0);
    chk("reset_stall", {31'd0, stall_id}, 32'd0);
    $display("[TB] reset state checked");
    rst_n = 1'b1;

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      clear_fwd();
      drive_id(vecs[i].valid, vecs[i].pc, vecs[i].rs1, vecs[i].rs1_data, vecs[i].rs2,
               vecs[i].rs2_data, vecs[i].imm, vecs[i].rd, vecs[i].alu, vecs[i].src_pc,
               vecs[i].src_imm, vecs[i].reg_write, 1'b0, 1'b0);
      sb.push_back(vecs[i]);
      @(posedge clk);
      #1;
      mem_rd_addr = vecs[i].m_rd; mem_reg_write = vecs[i].m_we; mem_alu_result = vecs[i].m_val;
      wb_rd_addr  = vecs[i].w_rd; wb_reg_write  = vecs[i].w_we; wb_data        = vecs[i].w_val;
      id_valid = 1'b0;
      #1;
      e = sb.pop_front();
      chk($sformatf("v%0d_valid", i), {31'd0, ex_valid}, {31'd0, e.valid});
      chk($sformatf("v%0d_alu", i), {28'd0, ex_alu_ctrl}, {28'd0, e.alu});
      chk($sformatf("v%0d_op1", i), ex_op1, e.e_op1);
      chk($sformatf("v%0d_op2", i), ex_op2, e.e_op2);
      chk($sformatf("v%0d_store", i), ex_store_data, e.e_store);
      chk($sformatf("v%0d_pc", i), ex_pc, e.pc);
      chk($sformatf("v%0d_stall", i), {31'd0, stall_id}, 32'd0);
      $display("[TB] vec %0d: op1=0x%08h op2=0x%08h store=0x%08h", i, ex_op1, ex_op2, ex_store_data);
    end

    // ---------------- load-use stall ----------------
    @(negedge clk);
    clear_fwd();
    drive_id(1, 32'h40, 5'd2, 32'h1000, 5'd0, 32'h0, 32'h4, 5'd7, ADD, 0, 1, 1, 1, 0);
    @(negedge clk);
    drive_id(1, 32'h44, 5'd8, 32'h80, 5'd7, 32'h0, 32'h0, 5'd12, SUB, 0, 0, 1, 0, 0);
    #1;
    chk("lu_stall", {31'd0, stall_id}, 32'd1);
    @(negedge clk);
    chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
    chk("lu_bubble_rw", {31'd0, ex_reg_write}, 32'd0);
    chk("lu_bubble_rd", {27'd0, ex_rd_addr}, 32'd0);
    chk("lu_stall_released", {31'd0, stall_id}, 32'd0);
    wb_rd_addr = 5'd7; wb_reg_write = 1'b1; wb_data = 32'hDEAD;
    @(negedge clk);
    chk("lu_sub_valid", {31'd0, ex_valid}, 32'd1);
    chk("lu_sub_alu", {28'd0, ex_alu_ctrl}, {28'd0, SUB});
    chk("lu_sub_op1", ex_op1, 32'h80);
    chk("lu_sub_op2_fwd", ex_op2, 32'hDEAD);
    $display("[TB] load-use: SUB op2=0x%08h", ex_op2);

    // ---------------- flush beats hazard ----------------
    clear_fwd();
    drive_id(1, 32'h50, 5'd2, 32'h1000, 5'd0, 32'h0, 32'h4, 5'd7, ADD, 0, 1, 1, 1, 0);
    @(negedge clk);
    drive_id(1, 32'h54, 5'd8, 32'h80, 5'd7, 32'h0, 32'h0, 5'd12, SUB, 0, 0, 1, 0, 0);
    flush = 1'b1;
    #1;
    chk("fl_stall", {31'd0, stall_id}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    chk("fl_valid", {31'd0, ex_valid}, 32'd0);
    chk("fl_rw", {31'd0, ex_reg_write}, 32'd0);
    $display("[TB] flush vs hazard: ex_valid=%0b", ex_valid);

    // ---------------- async reset mid-stream ----------------
    drive_id(1, 32'h200, 5'd1, 32'h11, 5'd2, 32'h22, 32'h0, 5'd3, XOR, 0, 0, 1, 0, 0);
    @(posedge clk);
    #2;
    chk("ar_pre_pc", ex_pc, 32'h200);
    rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'd0, ex_valid}, 32'd0);
    chk("ar_rw", {31'd0, ex_reg_write}, 32'd0);
    chk("ar_pc", ex_pc, 32'h0);
    chk("ar_alu", {28'd0, ex_alu_ctrl}, {28'd0, ADD});
`ifdef ID_EX_PERF_CNT_EN
    chk("ar_perf_stall", perf_stall_cnt, 32'd0);
    chk("ar_perf_flush", perf_flush_cnt, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    drive_id(1, 32'h300, 5'd1, 32'h11, 5'd2, 32'h22, 32'h0, 5'd3, ADD, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("ar_post_valid", {31'd0, ex_valid}, 32'd1);
    chk("ar_post_pc", ex_pc, 32'h300);
    chk("ar_post_op1", ex_op1, 32'h11);
    $display("[TB] async reset: post-release pc=0x%08h", ex_pc);

`ifdef ID_EX_PERF_CNT_EN
    id_valid = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("perf_flush_one", perf_flush_cnt, 32'd1);
    chk("perf_stall_zero", perf_stall_cnt, 32'd0);
    $display("[TB] perf: flush=%0d stall=%0d", perf_flush_cnt, perf_stall_cnt);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
